// File: rtl/alu_ctrl_exec.sv
// ALU control decode + execute with a single-entry registered output and
// valid/ready on both sides; shifts optionally run 1 bit per cycle.
module alu_ctrl_exec #(
    parameter int XLEN         = 32,
    parameter int SERIAL_SHIFT = 1,
    parameter int SHW          = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      alu_op,
    input  logic [2:0]      funct3,
    input  logic [6:0]      funct7,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic [3:0]      alu_control,
    output logic            illegal
);

    typedef enum logic [3:0] {
        C_AND  = 4'b0000, C_OR  = 4'b0001, C_ADD = 4'b0010, C_XOR = 4'b0011,
        C_SLT  = 4'b0100, C_SLTU = 4'b0101, C_SUB = 4'b0110,
        C_SLL  = 4'b0111, C_SRL = 4'b1000, C_SRA = 4'b1001,
        C_ILL  = 4'b1111
    } code_e;

    typedef enum logic {IDLE, SHIFT} state_e;

    state_e          state, state_nxt;
    code_e           dec_code, sh_code;
    logic [XLEN-1:0] exec_res, work, work_nxt;
    logic [SHW-1:0]  cnt, shamt;
    logic            is_shift, go_serial, accept;

    always_comb begin
        dec_code = C_ILL;
        case (alu_op)
            2'b00: dec_code = C_ADD;
            2'b01: dec_code = C_SUB;
            2'b10: begin
                case (funct3)
                    3'b000:  dec_code = (funct7 == 7'b0100000) ? C_SUB : C_ADD;
                    3'b001:  dec_code = C_SLL;
                    3'b010:  dec_code = C_SLT;
                    3'b011:  dec_code = C_SLTU;
                    3'b100:  dec_code = C_XOR;
                    3'b101:  dec_code = (funct7 == 7'b0100000) ? C_SRA : C_SRL;
                    3'b110:  dec_code = C_OR;
                    default: dec_code = C_AND;
                endcase
            end
            default: dec_code = C_ILL;
        endcase
    end

    assign shamt     = op_b[SHW-1:0];
    assign is_shift  = (dec_code == C_SLL) || (dec_code == C_SRL) || (dec_code == C_SRA);
    // Zero-distance shifts skip the iterative path and complete like any single-cycle op.
    assign go_serial = (SERIAL_SHIFT != 0) && is_shift && (shamt != '0);
    assign in_ready  = !rst && (state == IDLE) && (!out_valid || out_ready);
    assign accept    = in_valid && in_ready;

    always_comb begin
        exec_res = '0;
        case (dec_code)
            C_AND:   exec_res = op_a & op_b;
            C_OR:    exec_res = op_a | op_b;
            C_ADD:   exec_res = op_a + op_b;
            C_XOR:   exec_res = op_a ^ op_b;
            C_SLT:   exec_res = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(op_b)};
            C_SLTU:  exec_res = {{(XLEN-1){1'b0}}, op_a < op_b};
            C_SUB:   exec_res = op_a - op_b;
            C_SLL:   exec_res = op_a << shamt;
            C_SRL:   exec_res = op_a >> shamt;
            C_SRA:   exec_res = XLEN'($signed(op_a) >>> shamt);
            default: exec_res = '0;
        endcase
    end

    always_comb begin
        work_nxt = work;
        case (sh_code)
            C_SLL:   work_nxt = {work[XLEN-2:0], 1'b0};
            C_SRL:   work_nxt = {1'b0, work[XLEN-1:1]};
            C_SRA:   work_nxt = {work[XLEN-1], work[XLEN-1:1]};
            default: work_nxt = work;
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept && go_serial) state_nxt = SHIFT;
            SHIFT:   if (cnt == SHW'(1)) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid   <= 1'b0;
            result      <= '0;
            zero        <= 1'b0;
            alu_control <= 4'b0000;
            illegal     <= 1'b0;
            work        <= '0;
            cnt         <= '0;
            sh_code     <= C_AND;
        end else if (accept) begin
            if (go_serial) begin
                work      <= op_a;
                cnt       <= shamt;
                sh_code   <= dec_code;
                out_valid <= 1'b0;
            end else begin
                result      <= exec_res;
                zero        <= (exec_res == '0);
                alu_control <= dec_code;
                illegal     <= (dec_code == C_ILL);
                out_valid   <= 1'b1;
            end
        end else if (state == SHIFT) begin
            work <= work_nxt;
            cnt  <= cnt - SHW'(1);
            if (cnt == SHW'(1)) begin
                result      <= work_nxt;
                zero        <= (work_nxt == '0);
                alu_control <= sh_code;
                illegal     <= 1'b0;
                out_valid   <= 1'b1;
            end
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_ctrl_exec.sv
// Bench for alu_ctrl_exec: vector table through a scoreboard on the serial-shift
// instance, plus hand sequences for backpressure, busy shifter, reset and barrel mode.
module tb_alu_ctrl_exec;

    typedef struct {
        logic [1:0]  op;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic [3:0]  code;
        logic        ill;
        int          lat;
    } vec_t;

    typedef struct {
        logic [31:0] res;
        logic [3:0]  code;
        logic        ill;
        int          lat;
        int          acc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0, out_ready = 1'b0;
    logic        in_ready, out_valid, zero, illegal;
    logic [1:0]  alu_op = '0;
    logic [2:0]  funct3 = '0;
    logic [6:0]  funct7 = '0;
    logic [31:0] op_a = '0, op_b = '0, result;
    logic [3:0]  alu_control;

    logic        b_in_valid = 1'b0, b_out_ready = 1'b0;
    logic        b_in_ready, b_out_valid, b_zero, b_illegal;
    logic [1:0]  b_alu_op = '0;
    logic [2:0]  b_funct3 = '0;
    logic [6:0]  b_funct7 = '0;
    logic [31:0] b_op_a = '0, b_op_b = '0, b_result;
    logic [3:0]  b_alu_control;

    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    exp_t sb[$];
    exp_t cur;
    vec_t vt[18];

    always #5 clk = ~clk;

    alu_ctrl_exec #(.XLEN(32), .SERIAL_SHIFT(1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .alu_op(alu_op), .funct3(funct3), .funct7(funct7), .op_a(op_a), .op_b(op_b),
        .out_valid(out_valid), .out_ready(out_ready), .result(result), .zero(zero),
        .alu_control(alu_control), .illegal(illegal)
    );

    alu_ctrl_exec #(.XLEN(32), .SERIAL_SHIFT(0)) dut_barrel (
        .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .alu_op(b_alu_op), .funct3(b_funct3), .funct7(b_funct7), .op_a(b_op_a), .op_b(b_op_b),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .result(b_result), .zero(b_zero),
        .alu_control(b_alu_control), .illegal(b_illegal)
    );

    function automatic vec_t mk(logic [1:0] op, logic [2:0] f3, logic [6:0] f7,
                                logic [31:0] a, logic [31:0] b, logic [31:0] res,
                                logic [3:0] code, logic ill, int lat);
        vec_t v;
        v.op = op; v.f3 = f3; v.f7 = f7; v.a = a; v.b = b;
        v.res = res; v.code = code; v.ill = ill; v.lat = lat;
        return v;
    endfunction

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
        end
    endtask

    // One cycle: sample just after the falling edge, score outputs, record accepts.
    task automatic step(output bit acc);
        exp_t e;
        #1;
        acc = 1'b0;
        if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_out", 64'(out_valid), 64'(0));
            end else begin
                e = sb.pop_front();
                check("result", 64'(result), 64'(e.res));
                check("alu_control", 64'(alu_control), 64'(e.code));
                check("zero", 64'(zero), 64'(e.res == 32'h0));
                check("illegal", 64'(illegal), 64'(e.ill));
                if (e.lat != 0) check("latency", 64'(cyc - e.acc), 64'(e.lat));
            end
        end
        if (in_valid && in_ready) begin
            e = cur;
            e.acc = cyc;
            sb.push_back(e);
            acc = 1'b1;
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic set_req(input vec_t v);
        alu_op = v.op; funct3 = v.f3; funct7 = v.f7; op_a = v.a; op_b = v.b;
        cur.res = v.res; cur.code = v.code; cur.ill = v.ill; cur.lat = v.lat; cur.acc = 0;
        in_valid = 1'b1;
    endtask

    task automatic wait_accept();
        bit acc;
        acc = 1'b0;
        for (int k = 0; k < 40 && !acc; k++) step(acc);
        if (!acc) check("accept_timeout", 64'(0), 64'(1));
        in_valid = 1'b0;
    endtask

    task automatic issue(input vec_t v);
        set_req(v);
        wait_accept();
    endtask

    task automatic drain();
        bit acc;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 60 && sb.size() != 0; k++) step(acc);
        check("drain_timeout", 64'(sb.size()), 64'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bit acc;
        vt[0]  = mk(2'b10, 3'b000, 7'b0100000, 32'd5,        32'd7,        32'hFFFFFFFE, 4'b0110, 1'b0, 1);
        vt[1]  = mk(2'b10, 3'b101, 7'b0100000, 32'h80000000, 32'd4,        32'hF8000000, 4'b1001, 1'b0, 5);
        vt[2]  = mk(2'b10, 3'b010, 7'b0000000, 32'hFFFFFFFF, 32'd1,        32'd1,        4'b0100, 1'b0, 1);
        vt[3]  = mk(2'b10, 3'b011, 7'b0000000, 32'hFFFFFFFF, 32'd1,        32'd0,        4'b0101, 1'b0, 1);
        vt[4]  = mk(2'b10, 3'b000, 7'b0100000, 32'd9,        32'd9,        32'd0,        4'b0110, 1'b0, 1);
        vt[5]  = mk(2'b11, 3'b000, 7'b0000000, 32'h1234,     32'd5,        32'd0,        4'b1111, 1'b1, 1);
        vt[6]  = mk(2'b10, 3'b001, 7'b0000000, 32'h1234,     32'd0,        32'h1234,     4'b0111, 1'b0, 1);
        vt[7]  = mk(2'b00, 3'b111, 7'b0100000, 32'hFFFFFFFF, 32'd2,        32'd1,        4'b0010, 1'b0, 1);
        vt[8]  = mk(2'b01, 3'b000, 7'b0000000, 32'd0,        32'd1,        32'hFFFFFFFF, 4'b0110, 1'b0, 1);
        vt[9]  = mk(2'b10, 3'b111, 7'b0000000, 32'hF0F0,     32'hFF00,     32'hF000,     4'b0000, 1'b0, 1);
        vt[10] = mk(2'b10, 3'b110, 7'b0000000, 32'hF0F0,     32'hFF00,     32'hFFF0,     4'b0001, 1'b0, 1);
        vt[11] = mk(2'b10, 3'b100, 7'b0000000, 32'hF0F0,     32'hFF00,     32'h0FF0,     4'b0011, 1'b0, 1);
        vt[12] = mk(2'b10, 3'b101, 7'b0000000, 32'h80000000, 32'd4,        32'h08000000, 4'b1000, 1'b0, 5);
        vt[13] = mk(2'b10, 3'b001, 7'b0000000, 32'd1,        32'h25,       32'h20,       4'b0111, 1'b0, 6);
        vt[14] = mk(2'b10, 3'b000, 7'b0000000, 32'd7,        32'd3,        32'd10,       4'b0010, 1'b0, 1);
        vt[15] = mk(2'b10, 3'b101, 7'b0100000, 32'h40000000, 32'd1,        32'h20000000, 4'b1001, 1'b0, 2);
        vt[16] = mk(2'b10, 3'b010, 7'b0000000, 32'd1,        32'hFFFFFFFF, 32'd0,        4'b0100, 1'b0, 1);
        vt[17] = mk(2'b10, 3'b011, 7'b0000000, 32'd1,        32'hFFFFFFFF, 32'd1,        4'b0101, 1'b0, 1);

        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_result", 64'(result), 64'(0));
        check("rst_zero", 64'(zero), 64'(0));
        check("rst_alu_control", 64'(alu_control), 64'(0));
        check("rst_illegal", 64'(illegal), 64'(0));
        check("rst_in_ready", 64'(in_ready), 64'(1));
        @(negedge clk);

        // Table, issued back to back with the consumer always ready.
        out_ready = 1'b1;
        foreach (vt[i]) issue(vt[i]);
        drain();

        // Busy shifter: a waiting request is held off for the whole shift.
        issue(vt[1]);
        set_req(mk(2'b00, 3'b000, 7'b0, 32'd2, 32'd3, 32'd5, 4'b0010, 1'b0, 1));
        for (int k = 0; k < 4; k++) begin
            #1;
            check("shift_in_ready", 64'(in_ready), 64'(0));
            check("shift_out_valid", 64'(out_valid), 64'(0));
            step(acc);
        end
        wait_accept();
        drain();

        // Backpressure, then drain and accept on the same edge.
        out_ready = 1'b0;
        issue(mk(2'b00, 3'b000, 7'b0, 32'd10, 32'd20, 32'd30, 4'b0010, 1'b0, 0));
        set_req(mk(2'b01, 3'b000, 7'b0, 32'd50, 32'd8, 32'd42, 4'b0110, 1'b0, 1));
        for (int k = 0; k < 3; k++) begin
            #1;
            check("bp_in_ready", 64'(in_ready), 64'(0));
            check("bp_out_valid", 64'(out_valid), 64'(1));
            check("bp_result_hold", 64'(result), 64'(30));
            step(acc);
        end
        out_ready = 1'b1;
        step(acc);
        check("bp_same_edge_accept", 64'(acc), 64'(1));
        in_valid = 1'b0;
        #1;
        check("bp_new_valid", 64'(out_valid), 64'(1));
        check("bp_new_result", 64'(result), 64'(42));
        drain();

        // Reset in the middle of a serial shift.
        issue(mk(2'b10, 3'b001, 7'b0, 32'd1, 32'd20, 32'h00100000, 4'b0111, 1'b0, 0));
        step(acc);
        step(acc);
        rst = 1'b1;
        #1;
        check("rst_mid_out_valid", 64'(out_valid), 64'(0));
        check("rst_mid_result", 64'(result), 64'(0));
        check("rst_mid_alu_control", 64'(alu_control), 64'(0));
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_rel_in_ready", 64'(in_ready), 64'(1));
        check("rst_rel_out_valid", 64'(out_valid), 64'(0));
        @(negedge clk);
        issue(mk(2'b00, 3'b000, 7'b0, 32'd2, 32'd3, 32'd5, 4'b0010, 1'b0, 1));
        drain();

        // Barrel-shift instance: same shifts complete at latency 1.
        b_out_ready = 1'b1;
        b_alu_op = 2'b10; b_funct3 = 3'b101; b_funct7 = 7'b0100000;
        b_op_a = 32'h80000000; b_op_b = 32'd4; b_in_valid = 1'b1;
        #1;
        check("barrel_in_ready", 64'(b_in_ready), 64'(1));
        @(negedge clk);
        b_funct3 = 3'b001; b_funct7 = 7'b0; b_op_a = 32'd1; b_op_b = 32'h25;
        #1;
        check("barrel_sra_valid", 64'(b_out_valid), 64'(1));
        check("barrel_sra_result", 64'(b_result), 64'hF8000000);
        check("barrel_sra_code", 64'(b_alu_control), 64'(4'b1001));
        @(negedge clk);
        b_in_valid = 1'b0;
        #1;
        check("barrel_sll_valid", 64'(b_out_valid), 64'(1));
        check("barrel_sll_result", 64'(b_result), 64'h20);
        check("barrel_sll_code", 64'(b_alu_control), 64'(4'b0111));
        @(negedge clk);
        #1;
        check("barrel_idle_valid", 64'(b_out_valid), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
